// File: rtl/obi_to_axi_pkg.sv
// obi_to_axi_pkg: bus widths, OBI/AXI channel structs and attribute mapping for the OBI-to-AXI bridge
package obi_to_axi_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth = 4;
  localparam int unsigned AxiIdWidth = 1;
  localparam bit UseProt = 1'b1;
  localparam bit UseMemtype = 1'b1;
  localparam logic [2:0] AxiSize = 3'($clog2(DataWidth / 8));
  localparam logic [1:0] BurstIncr = 2'b01;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;
  typedef struct packed {
    logic                   req;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic [IdWidth-1:0]     aid;
    logic [2:0]             prot;
    logic [1:0]             memtype;
  } obi_req_t;
  typedef struct packed {
    logic                 gnt;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
    logic                 err;
    logic [IdWidth-1:0]   rid;
  } obi_rsp_t;
  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
  } axi_ax_t;
  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } axi_w_t;
  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_t;
  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;
  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    axi_ax_t ar;
    logic    ar_valid;
    logic    b_ready;
    logic    r_ready;
  } axi_req_t;
  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   ar_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;
  function automatic logic [2:0] map_prot(input logic [2:0] p);
    return UseProt ? {~p[0], 1'b0, ~p[1]} : 3'b000;
  endfunction
  function automatic logic [3:0] map_cache(input logic [1:0] m);
    return UseMemtype ? {2'b00, ~m[1], m[0]} : 4'b0000;
  endfunction
endpackage

// File: rtl/obi_to_axi_order_fifo.sv
// obi_to_axi_order_fifo: sync-reset FIFO remembering {we, aid} of granted requests in issue order
module obi_to_axi_order_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] Last = PtrW'(Depth - 1);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  assign full_o = cnt_q == CntW'(Depth);
  assign empty_o = cnt_q == '0;
  assign head_o = mem_q[rd_q];
  // pointer, storage and occupancy update; push and pop may coincide
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wr_q] = data_i;
    wr_d = push_i ? (wr_q == Last ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop_i ? (rd_q == Last ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/obi_to_axi.sv
// obi_to_axi: OBI subordinate to single-beat AXI4 manager bridge with in-order registered R phase
module obi_to_axi
  import obi_to_axi_pkg::*;
#(
  parameter logic [AxiIdWidth-1:0] AxiId = '0,
  parameter int unsigned MaxTrans = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output axi_req_t axi_req_o,
  input  axi_rsp_t axi_rsp_i
);
  localparam int unsigned FifoWidth = 1 + IdWidth;
  logic en_q, en_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rvalid_q, rvalid_d, err_q, err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [IdWidth-1:0] rid_q, rid_d;
  logic active, rd_req, wr_req, full, empty, gnt, pop, head_we;
  logic [IdWidth-1:0] head_aid;
  logic [FifoWidth-1:0] head;
  logic unused;
  assign {head_we, head_aid} = head;
  assign unused = ^{axi_rsp_i.r.id, axi_rsp_i.r.last, axi_rsp_i.b.id};
  obi_to_axi_order_fifo #(
    .Depth(MaxTrans),
    .Width(FifoWidth)
  ) u_order_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (gnt),
    .data_i ({obi_req_i.we, obi_req_i.aid}),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );
  // AXI request channels, OBI grant and response acceptance; en_q masks the cycle after reset
  always_comb begin
    active = en_q & ~rst_i;
    rd_req = active & obi_req_i.req & ~obi_req_i.we;
    wr_req = active & obi_req_i.req & obi_req_i.we;
    axi_req_o = '0;
    axi_req_o.aw.id = AxiId;
    axi_req_o.aw.addr = obi_req_i.addr;
    axi_req_o.aw.size = AxiSize;
    axi_req_o.aw.burst = BurstIncr;
    axi_req_o.aw.cache = map_cache(obi_req_i.memtype);
    axi_req_o.aw.prot = map_prot(obi_req_i.prot);
    axi_req_o.ar = axi_req_o.aw;
    axi_req_o.w.data = obi_req_i.wdata;
    axi_req_o.w.strb = obi_req_i.be;
    axi_req_o.w.last = 1'b1;
    axi_req_o.aw_valid = wr_req & ~full & ~aw_done_q;
    axi_req_o.w_valid = wr_req & ~full & ~w_done_q;
    axi_req_o.ar_valid = rd_req & ~full;
    axi_req_o.b_ready = active & ~empty & head_we;
    axi_req_o.r_ready = active & ~empty & ~head_we;
    gnt = rd_req ? axi_rsp_i.ar_ready & ~full
                 : wr_req & ~full & (axi_rsp_i.aw_ready | aw_done_q) & (axi_rsp_i.w_ready | w_done_q);
    pop = (axi_req_o.b_ready & axi_rsp_i.b_valid) | (axi_req_o.r_ready & axi_rsp_i.r_valid);
  end
  // sticky write-channel flags and registered R phase captured on the accepted B/R handshake
  always_comb begin
    en_d = 1'b1;
    aw_done_d = gnt ? 1'b0 : aw_done_q | (axi_req_o.aw_valid & axi_rsp_i.aw_ready);
    w_done_d = gnt ? 1'b0 : w_done_q | (axi_req_o.w_valid & axi_rsp_i.w_ready);
    rvalid_d = pop;
    rdata_d = pop ? (head_we ? '0 : axi_rsp_i.r.data) : rdata_q;
    err_d = pop ? (head_we ? axi_rsp_i.b.resp[1] : axi_rsp_i.r.resp[1]) : err_q;
    rid_d = pop ? head_aid : rid_q;
  end
  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      rid_q <= '0;
    end else begin
      en_q <= en_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      rid_q <= rid_d;
    end
  end
  assign obi_rsp_o.gnt = gnt;
  assign obi_rsp_o.rvalid = rvalid_q;
  assign obi_rsp_o.rdata = rdata_q;
  assign obi_rsp_o.err = err_q;
  assign obi_rsp_o.rid = rid_q;
endmodule

// File: tb/tb_obi_to_axi.sv
// tb_obi_to_axi: directed checks of the OBI-to-AXI bridge with hand-computed expectations
module tb_obi_to_axi;
  import obi_to_axi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  obi_req_t oreq;
  obi_rsp_t orsp;
  axi_req_t areq;
  axi_rsp_t arsp;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  obi_to_axi #(
    .AxiId   (1'b0),
    .MaxTrans(2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .obi_req_i(oreq),
    .obi_rsp_o(orsp),
    .axi_req_o(areq),
    .axi_rsp_i(arsp)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic obi_rd(input logic [31:0] addr, input logic [3:0] aid);
    oreq = '0;
    oreq.req = 1'b1;
    oreq.addr = addr;
    oreq.aid = aid;
  endtask
  task automatic obi_wr(input logic [31:0] addr, input logic [3:0] aid, input logic [3:0] be, input logic [31:0] wdata);
    oreq = '0;
    oreq.req = 1'b1;
    oreq.we = 1'b1;
    oreq.addr = addr;
    oreq.aid = aid;
    oreq.be = be;
    oreq.wdata = wdata;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    oreq = '0;
    arsp = '0;
    repeat (2) next_cycle();
    obi_rd(32'h100, 4'd3);
    oreq.prot = 3'b001;
    oreq.memtype = 2'b01;
    arsp.ar_ready = 1'b1;
    arsp.aw_ready = 1'b1;
    arsp.w_ready = 1'b1;
    #1;
    check("rst_gnt", orsp.gnt, 0);
    check("rst_arvalid", areq.ar_valid, 0);
    check("rst_rvalid", orsp.rvalid, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rel_gnt", orsp.gnt, 0);
    check("rel_arvalid", areq.ar_valid, 0);
    check("rel_rready", areq.r_ready, 0);
    next_cycle();
    #1;
    check("rd_gnt", orsp.gnt, 1);
    check("rd_arvalid", areq.ar_valid, 1);
    check("rd_addr", areq.ar.addr, 32'h100);
    check("rd_size", areq.ar.size, 2);
    check("rd_burst", areq.ar.burst, 1);
    check("rd_len", areq.ar.len, 0);
    check("rd_prot", areq.ar.prot, 3'b001);
    check("rd_cache", areq.ar.cache, 4'b0011);
    check("rd_id", areq.ar.id, 0);
    next_cycle();
    oreq = '0;
    arsp.r_valid = 1'b1;
    arsp.r.data = 32'hDEADBEEF;
    arsp.r.resp = RESP_OKAY;
    #1;
    check("rd_rready", areq.r_ready, 1);
    check("rd_rvalid_early", orsp.rvalid, 0);
    next_cycle();
    arsp.r_valid = 1'b0;
    #1;
    check("rd_rvalid", orsp.rvalid, 1);
    check("rd_rdata", orsp.rdata, 32'hDEADBEEF);
    check("rd_err", orsp.err, 0);
    check("rd_rid", orsp.rid, 3);
    next_cycle();
    #1;
    check("rd_pulse", orsp.rvalid, 0);
    next_cycle();
    obi_wr(32'h200, 4'd5, 4'b0011, 32'h1234);
    arsp.aw_ready = 1'b0;
    #1;
    check("wr_awvalid", areq.aw_valid, 1);
    check("wr_wvalid", areq.w_valid, 1);
    check("wr_gnt_c0", orsp.gnt, 0);
    check("wr_strb", areq.w.strb, 4'b0011);
    check("wr_last", areq.w.last, 1);
    check("wr_wdata", areq.w.data, 32'h1234);
    next_cycle();
    #1;
    check("wr_wvalid_done", areq.w_valid, 0);
    check("wr_awvalid_hold", areq.aw_valid, 1);
    check("wr_gnt_c1", orsp.gnt, 0);
    next_cycle();
    #1;
    check("wr_gnt_c2", orsp.gnt, 0);
    next_cycle();
    arsp.aw_ready = 1'b1;
    #1;
    check("wr_gnt", orsp.gnt, 1);
    check("wr_wvalid_gnt", areq.w_valid, 0);
    next_cycle();
    oreq = '0;
    arsp.b_valid = 1'b1;
    arsp.b.resp = RESP_OKAY;
    #1;
    check("wr_bready", areq.b_ready, 1);
    check("wr_rready", areq.r_ready, 0);
    next_cycle();
    arsp.b_valid = 1'b0;
    #1;
    check("wr_rvalid", orsp.rvalid, 1);
    check("wr_err", orsp.err, 0);
    check("wr_rdata", orsp.rdata, 0);
    check("wr_rid", orsp.rid, 5);
    next_cycle();
    obi_wr(32'h300, 4'd1, 4'hF, 32'hAA);
    #1;
    check("ord_wr_gnt", orsp.gnt, 1);
    next_cycle();
    obi_rd(32'h304, 4'd2);
    #1;
    check("ord_rd_gnt", orsp.gnt, 1);
    next_cycle();
    oreq = '0;
    arsp.r_valid = 1'b1;
    arsp.r.data = 32'hCAFE;
    arsp.r.resp = RESP_OKAY;
    #1;
    check("ord_rready_blocked", areq.r_ready, 0);
    check("ord_bready", areq.b_ready, 1);
    next_cycle();
    arsp.b_valid = 1'b1;
    arsp.b.resp = RESP_OKAY;
    #1;
    check("ord_rvalid_none", orsp.rvalid, 0);
    next_cycle();
    arsp.b_valid = 1'b0;
    #1;
    check("ord_rsp1_valid", orsp.rvalid, 1);
    check("ord_rsp1_rid", orsp.rid, 1);
    check("ord_rsp1_rdata", orsp.rdata, 0);
    check("ord_rready", areq.r_ready, 1);
    next_cycle();
    arsp.r_valid = 1'b0;
    #1;
    check("ord_rsp2_valid", orsp.rvalid, 1);
    check("ord_rsp2_rid", orsp.rid, 2);
    check("ord_rsp2_rdata", orsp.rdata, 32'hCAFE);
    next_cycle();
    obi_rd(32'h10, 4'd4);
    #1;
    check("full_gnt0", orsp.gnt, 1);
    next_cycle();
    obi_rd(32'h14, 4'd5);
    #1;
    check("full_gnt1", orsp.gnt, 1);
    next_cycle();
    obi_rd(32'h18, 4'd6);
    #1;
    check("full_gnt2", orsp.gnt, 0);
    check("full_arvalid", areq.ar_valid, 0);
    next_cycle();
    arsp.r_valid = 1'b1;
    arsp.r.data = 32'h11;
    arsp.r.resp = RESP_DECERR;
    #1;
    check("full_gnt_on_pop", orsp.gnt, 0);
    check("full_rready", areq.r_ready, 1);
    next_cycle();
    arsp.r_valid = 1'b0;
    #1;
    check("full_gnt_after", orsp.gnt, 1);
    check("full_arvalid_after", areq.ar_valid, 1);
    check("decerr_rvalid", orsp.rvalid, 1);
    check("decerr_rid", orsp.rid, 4);
    check("decerr_err", orsp.err, 1);
    check("decerr_rdata", orsp.rdata, 32'h11);
    next_cycle();
    oreq = '0;
    arsp.r_valid = 1'b1;
    arsp.r.data = 32'h22;
    arsp.r.resp = RESP_OKAY;
    next_cycle();
    arsp.r.data = 32'h33;
    #1;
    check("drain1_rid", orsp.rid, 5);
    check("drain1_err", orsp.err, 0);
    check("drain1_rdata", orsp.rdata, 32'h22);
    next_cycle();
    arsp.r_valid = 1'b0;
    #1;
    check("drain2_rvalid", orsp.rvalid, 1);
    check("drain2_rid", orsp.rid, 6);
    check("drain2_rdata", orsp.rdata, 32'h33);
    next_cycle();
    obi_wr(32'h400, 4'd7, 4'hF, 32'h77);
    oreq.prot = 3'b010;
    oreq.memtype = 2'b10;
    #1;
    check("slv_gnt", orsp.gnt, 1);
    check("slv_awprot", areq.aw.prot, 3'b100);
    check("slv_awcache", areq.aw.cache, 4'b0000);
    next_cycle();
    oreq = '0;
    arsp.b_valid = 1'b1;
    arsp.b.resp = RESP_SLVERR;
    next_cycle();
    arsp.b_valid = 1'b0;
    #1;
    check("slv_rvalid", orsp.rvalid, 1);
    check("slv_err", orsp.err, 1);
    check("slv_rid", orsp.rid, 7);
    next_cycle();
    obi_rd(32'h20, 4'd8);
    #1;
    check("rs_gnt0", orsp.gnt, 1);
    next_cycle();
    obi_rd(32'h24, 4'd9);
    #1;
    check("rs_gnt1", orsp.gnt, 1);
    next_cycle();
    obi_rd(32'h28, 4'd10);
    rst = 1'b1;
    #1;
    check("rs_gnt_in_rst", orsp.gnt, 0);
    check("rs_arvalid_in_rst", areq.ar_valid, 0);
    check("rs_rready_in_rst", areq.r_ready, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rs_rvalid", orsp.rvalid, 0);
    check("rs_err", orsp.err, 0);
    check("rs_rid", orsp.rid, 0);
    check("rs_gnt_rel", orsp.gnt, 0);
    next_cycle();
    oreq = '0;
    #1;
    check("rs_fifo_empty", areq.r_ready, 0);
    next_cycle();
    obi_rd(32'h500, 4'd11);
    #1;
    check("rs_new_gnt", orsp.gnt, 1);
    next_cycle();
    oreq = '0;
    arsp.r_valid = 1'b1;
    arsp.r.data = 32'h55;
    arsp.r.resp = RESP_OKAY;
    #1;
    check("rs_new_rready", areq.r_ready, 1);
    next_cycle();
    arsp.r_valid = 1'b0;
    #1;
    check("rs_new_rvalid", orsp.rvalid, 1);
    check("rs_new_rid", orsp.rid, 11);
    check("rs_new_rdata", orsp.rdata, 32'h55);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
